isdu_gen2: RTL and testbench

ISDU_GEN2 -- requirements
Module: isdu_gen2

---
 rtl/isdu_gen2.sv | 165 ++++++++++++++++
 tb/tb_isdu_gen2.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/isdu_gen2.sv
// isdu_gen2: LC-3 style instruction sequencer with fixed-latency or ready-handshake memory timing.
module isdu_gen2 #(
  parameter int MEM_WAIT = 4,
  parameter int USE_RDY  = 0,
  parameter int PAUSE_EN = 1
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Run,
  input  logic       Continue,
  input  logic       Mem_Rdy,
  input  logic [3:0] Opcode,
  input  logic       IR_5,
  input  logic       IR_11,
  input  logic       BEN,
  output logic       LD_MAR,
  output logic       LD_MDR,
  output logic       LD_IR,
  output logic       LD_BEN,
  output logic       LD_CC,
  output logic       LD_REG,
  output logic       LD_PC,
  output logic       LD_LED,
  output logic       GatePC,
  output logic       GateMDR,
  output logic       GateALU,
  output logic       GateMARMUX,
  output logic [1:0] PCMUX,
  output logic [1:0] ADDR2MUX,
  output logic [1:0] ALUK,
  output logic       DRMUX,
  output logic       SR1MUX,
  output logic       SR2MUX,
  output logic       ADDR1MUX,
  output logic       Mem_OE,
  output logic       Mem_WE
);
  typedef enum logic [4:0] {
    HALTED, FETCH, FETCH_MEM, IR_LD, DECODE, ADD, AND, NOT, LDR_A, LD_A, LD_MEM, LD_WB,
    STR_A, ST_A, ST_MDR, ST_MEM, LEA, JSR_SAVE, JSR_JMP, JMP, BR, BR_TAKEN, PAUSE1, PAUSE2
  } state_t;
  state_t state, nxt;
  logic [3:0] cnt;
  logic mem_st, nxt_mem, done;
  assign mem_st  = state inside {FETCH_MEM, LD_MEM, ST_MEM};
  assign nxt_mem = nxt inside {FETCH_MEM, LD_MEM, ST_MEM};
  assign done    = (USE_RDY != 0) ? Mem_Rdy : (cnt == 4'd0);
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= HALTED;
      cnt   <= 4'd0;
    end else begin
      state <= nxt;
      if (!mem_st && nxt_mem) cnt <= 4'(MEM_WAIT - 1);
      else if (mem_st && cnt != 4'd0) cnt <= cnt - 4'd1;
    end
  end
  always_comb begin
    nxt = state;
    {LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED} = '0;
    {GatePC, GateMDR, GateALU, GateMARMUX} = '0;
    {PCMUX, ADDR2MUX, ALUK} = '0;
    {DRMUX, SR1MUX, SR2MUX, ADDR1MUX, Mem_OE, Mem_WE} = '0;
    unique case (state)
      HALTED: nxt = Run ? FETCH : HALTED;
      FETCH: begin
        {GatePC, LD_MAR, LD_PC} = '1;
        nxt = FETCH_MEM;
      end
      FETCH_MEM, LD_MEM: begin
        Mem_OE = 1'b1;
        LD_MDR = done;
        nxt = !done ? state : (state == FETCH_MEM) ? IR_LD : LD_WB;
      end
      ST_MEM: begin
        Mem_WE = 1'b1;
        nxt = done ? FETCH : ST_MEM;
      end
      IR_LD: begin
        {GateMDR, LD_IR} = '1;
        nxt = DECODE;
      end
      DECODE: begin
        LD_BEN = 1'b1;
        unique case (Opcode)
          4'b0001: nxt = ADD;
          4'b0101: nxt = AND;
          4'b1001: nxt = NOT;
          4'b0110: nxt = LDR_A;
          4'b0010: nxt = LD_A;
          4'b0111: nxt = STR_A;
          4'b0011: nxt = ST_A;
          4'b1110: nxt = LEA;
          4'b0100: nxt = JSR_SAVE;
          4'b1100: nxt = JMP;
          4'b0000: nxt = BR;
          4'b1101: nxt = (PAUSE_EN != 0) ? PAUSE1 : FETCH;
          default: nxt = FETCH;
        endcase
      end
      ADD, AND, NOT: begin
        ALUK = (state == ADD) ? 2'b00 : (state == AND) ? 2'b01 : 2'b10;
        SR2MUX = (state != NOT) && IR_5;
        {GateALU, SR1MUX, LD_REG, LD_CC} = '1;
        nxt = FETCH;
      end
      LDR_A, STR_A, LD_A, ST_A: begin
        ADDR1MUX = state inside {LDR_A, STR_A};
        ADDR2MUX = ADDR1MUX ? 2'b01 : 2'b10;
        SR1MUX = ADDR1MUX;
        {GateMARMUX, LD_MAR} = '1;
        nxt = (state inside {LDR_A, LD_A}) ? LD_MEM : ST_MDR;
      end
      LD_WB: begin
        {GateMDR, LD_REG, LD_CC} = '1;
        nxt = FETCH;
      end
      ST_MDR: begin
        ALUK = 2'b11;
        {GateALU, LD_MDR} = '1;
        nxt = ST_MEM;
      end
      LEA: begin
        ADDR2MUX = 2'b10;
        {GateMARMUX, LD_REG, LD_CC} = '1;
        nxt = FETCH;
      end
      JSR_SAVE: begin
        {GatePC, DRMUX, LD_REG} = '1;
        nxt = JSR_JMP;
      end
      JSR_JMP: begin
        LD_PC = 1'b1;
        PCMUX = IR_11 ? 2'b10 : 2'b01;
        ADDR2MUX = IR_11 ? 2'b11 : 2'b00;
        SR1MUX = !IR_11;
        ALUK = IR_11 ? 2'b00 : 2'b11;
        GateALU = !IR_11;
        nxt = FETCH;
      end
      JMP: begin
        ALUK = 2'b11;
        PCMUX = 2'b01;
        {SR1MUX, GateALU, LD_PC} = '1;
        nxt = FETCH;
      end
      BR: nxt = BEN ? BR_TAKEN : FETCH;
      BR_TAKEN: begin
        ADDR2MUX = 2'b10;
        PCMUX = 2'b10;
        LD_PC = 1'b1;
        nxt = FETCH;
      end
      PAUSE1: begin
        LD_LED = 1'b1;
        nxt = Continue ? PAUSE2 : PAUSE1;
      end
      PAUSE2: begin
        LD_LED = 1'b1;
        nxt = Continue ? PAUSE2 : FETCH;
      end
      default: nxt = HALTED;
    endcase
  end
endmodule

// File: tb/tb_isdu_gen2.sv
// tb_isdu_gen2: directed checks of four sequencer variants (default, MEM_WAIT=1, ready mode, no pause).
module tb_isdu_gen2;
  logic Clk = 0, Reset = 0, Run = 0, Continue = 0, Mem_Rdy = 0;
  logic [3:0] Opcode = 4'b0001;
  logic IR_5 = 0, IR_11 = 0, BEN = 0;
  logic [23:0] o [4];
  int checks = 0, failures = 0;
  always #5 Clk = ~Clk;
  // Output word: LD_MAR..LD_LED, gates, PCMUX, ADDR2MUX, ALUK, DRMUX, SR1MUX, SR2MUX, ADDR1MUX, OE, WE
  localparam logic [23:0] FETCH_V = 24'h828000, OE_V = 24'h000002, OE_END = 24'h400002;
  localparam logic [23:0] IRLD_V = 24'h204000, DEC_V = 24'h100000, ADDI_V = 24'h0C2018;
  localparam logic [23:0] ADDR_V = 24'h801114, LDWB_V = 24'h0C4000, STMDR_V = 24'h4020C0;
  localparam logic [23:0] WE_V = 24'h000001, BRT_V = 24'h020A00, JSV_V = 24'h048020;
  localparam logic [23:0] JSRR_V = 24'h0224D0, LED_V = 24'h010000;
  for (genvar g = 0; g < 4; g++) begin : g_dut
    isdu_gen2 #(.MEM_WAIT(g == 1 ? 1 : 4), .USE_RDY(g == 2 ? 1 : 0), .PAUSE_EN(g == 3 ? 0 : 1)) u (
      .Clk(Clk), .Reset(Reset), .Run(Run), .Continue(Continue), .Mem_Rdy(Mem_Rdy),
      .Opcode(Opcode), .IR_5(IR_5), .IR_11(IR_11), .BEN(BEN),
      .LD_MAR(o[g][23]), .LD_MDR(o[g][22]), .LD_IR(o[g][21]), .LD_BEN(o[g][20]),
      .LD_CC(o[g][19]), .LD_REG(o[g][18]), .LD_PC(o[g][17]), .LD_LED(o[g][16]),
      .GatePC(o[g][15]), .GateMDR(o[g][14]), .GateALU(o[g][13]), .GateMARMUX(o[g][12]),
      .PCMUX(o[g][11:10]), .ADDR2MUX(o[g][9:8]), .ALUK(o[g][7:6]),
      .DRMUX(o[g][5]), .SR1MUX(o[g][4]), .SR2MUX(o[g][3]), .ADDR1MUX(o[g][2]),
      .Mem_OE(o[g][1]), .Mem_WE(o[g][0]));
  end
  task automatic chk(input string tag, input int idx, input logic [23:0] exp);
    checks++;
    assert (o[idx] === exp) else begin
      failures++;
      $error("FAIL %s dut%0d got=%h exp=%h", tag, idx, o[idx], exp);
    end
  endtask
  task automatic step(input string tag, input int idx, input logic [23:0] exp);
    @(posedge Clk);
    #1;
    chk(tag, idx, exp);
  endtask
  // Reset (with Run held to prove reset priority), then a Run pulse into FETCH.
  task automatic start(input int idx);
    Reset = 1;
    Run = 1;
    step("reset_prio", idx, 24'h0);
    Reset = 0;
    step("fetch", idx, FETCH_V);
    Run = 0;
  endtask
  task automatic fetch_decode(input int idx);
    start(idx);
    for (int i = 0; i < 3; i++) step("fetch_mem", idx, OE_V);
    step("fetch_mem_end", idx, OE_END);
    step("ir_ld", idx, IRLD_V);
    step("decode", idx, DEC_V);
  endtask
  initial begin
    Reset = 1;
    @(posedge Clk);
    #1;
    for (int i = 0; i < 4; i++) chk("reset_state", i, 24'h0);
    Reset = 0;
    step("halted_hold", 0, 24'h0);
    Opcode = 4'b0001;
    IR_5 = 1;
    fetch_decode(0);
    step("add_imm", 0, ADDI_V);
    step("add_next_fetch", 0, FETCH_V);
    Opcode = 4'b0110;
    fetch_decode(0);
    step("ldr_a", 0, ADDR_V);
    for (int i = 0; i < 3; i++) step("ld_mem", 0, OE_V);
    step("ld_mem_end", 0, OE_END);
    step("ld_wb", 0, LDWB_V);
    step("ldr_next_fetch", 0, FETCH_V);
    start(1);
    step("w1_fetch_mem", 1, OE_END);
    step("w1_ir_ld", 1, IRLD_V);
    step("w1_decode", 1, DEC_V);
    step("w1_ldr_a", 1, ADDR_V);
    step("w1_ld_mem", 1, OE_END);
    step("w1_ld_wb", 1, LDWB_V);
    step("w1_next_fetch", 1, FETCH_V);
    Opcode = 4'b1111;
    start(2);
    step("rdy_wait1", 2, OE_V);
    step("rdy_wait2", 2, OE_V);
    Mem_Rdy = 1;
    #1;
    chk("rdy_end3", 2, OE_END);
    step("rdy_ir_ld", 2, IRLD_V);
    Mem_Rdy = 0;
    step("rdy_decode", 2, DEC_V);
    step("rdy_nop_fetch", 2, FETCH_V);
    Mem_Rdy = 1;
    step("rdy_entry_end", 2, OE_END);
    step("rdy_entry_ir_ld", 2, IRLD_V);
    Mem_Rdy = 0;
    Opcode = 4'b0111;
    fetch_decode(0);
    step("str_a", 0, ADDR_V);
    step("st_mdr", 0, STMDR_V);
    step("st_mem1", 0, WE_V);
    step("st_mem2", 0, WE_V);
    Reset = 1;
    step("st_reset_halted", 0, 24'h0);
    Reset = 0;
    step("st_halted_idle", 0, 24'h0);
    Run = 1;
    step("st_restart_fetch", 0, FETCH_V);
    Run = 0;
    Opcode = 4'b0000;
    BEN = 0;
    fetch_decode(0);
    step("br_not_taken", 0, 24'h0);
    step("br_nt_fetch", 0, FETCH_V);
    BEN = 1;
    fetch_decode(0);
    step("br", 0, 24'h0);
    step("br_taken", 0, BRT_V);
    step("br_t_fetch", 0, FETCH_V);
    BEN = 0;
    Opcode = 4'b0100;
    IR_11 = 0;
    fetch_decode(0);
    step("jsr_save", 0, JSV_V);
    step("jsrr_jmp", 0, JSRR_V);
    step("jsr_fetch", 0, FETCH_V);
    Opcode = 4'b1101;
    fetch_decode(0);
    step("pause1", 0, LED_V);
    step("pause1_hold", 0, LED_V);
    Continue = 1;
    step("pause2", 0, LED_V);
    step("pause2_hold", 0, LED_V);
    Continue = 0;
    step("pause_fetch", 0, FETCH_V);
    fetch_decode(3);
    step("nopause_fetch", 3, FETCH_V);
    step("nopause_fetch_mem", 3, OE_V);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
